// File: rtl/serial_rx_if.sv
// rtl/serial_rx_if.sv - serial line input and receive-FIFO write port of the frame deserializer
interface serial_rx_if #(parameter int DSIZE = 32);
  logic             s_in;
  logic             wfull;
  logic             w_en;
  logic [DSIZE:0]   wdata;
  logic             in_frame;
  logic             frame_err;
  logic             overflow;

  modport master (
    input  s_in, wfull,
    output w_en, wdata, in_frame, frame_err, overflow
  );

  modport slave (
    output s_in, wfull,
    input  w_en, wdata, in_frame, frame_err, overflow
  );
endinterface

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - frame deserializer: SOF hunt, 32-bit word assembly with one-word holdback, EOF tail check
module serial_rx #(
  parameter int          DSIZE   = 32,
  parameter logic [31:0] SOF_PAT = 32'h5a5a5a5a,
  parameter logic [15:0] EOF_PAT = 16'h0f0f
) (
  input  logic         rclk,
  input  logic         rrst,
  serial_rx_if.master  bus
);

  localparam logic [31:0] EOF_WORD = {EOF_PAT, EOF_PAT};

  typedef enum logic [1:0] {HUNT, DATA, TAIL} state_t;

  state_t           state, state_d;
  logic [31:0]      window, window_d;
  logic [5:0]       cnt, cnt_d;
  logic [DSIZE-1:0] pend, pend_d;
  logic             pend_valid, pend_valid_d;
  logic             w_en_q, w_en_d;
  logic [DSIZE:0]   wdata_q, wdata_d;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q, overflow_d;
  logic             do_write, write_eof, exp_bit;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state       <= HUNT;
      window      <= '0;
      cnt         <= '0;
      pend        <= '0;
      pend_valid  <= 1'b0;
      w_en_q      <= 1'b0;
      wdata_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state       <= state_d;
      window      <= window_d;
      cnt         <= cnt_d;
      pend        <= pend_d;
      pend_valid  <= pend_valid_d;
      w_en_q      <= w_en_d;
      wdata_q     <= wdata_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    window_d     = {window[30:0], bus.s_in};
    state_d      = state;
    cnt_d        = cnt + 6'd1;
    pend_d       = pend;
    pend_valid_d = pend_valid;
    w_en_d       = 1'b0;
    wdata_d      = wdata_q;
    frame_err_d  = 1'b0;
    overflow_d   = 1'b0;
    do_write     = 1'b0;
    write_eof    = 1'b0;
    // Tail index 0..47 maps onto EOF_PAT bits 15..0 repeating; 16 divides evenly so low nibble suffices.
    exp_bit      = EOF_PAT[4'd15 - cnt[3:0]];

    case (state)
      HUNT: begin
        cnt_d = '0;
        if (window_d == SOF_PAT) state_d = DATA;
      end
      DATA: begin
        if (cnt == 6'd31) begin
          cnt_d = '0;
          if (window_d == EOF_WORD) begin
            state_d      = TAIL;
            pend_valid_d = 1'b0;
            if (pend_valid) begin
              do_write  = 1'b1;
              write_eof = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            do_write     = pend_valid;
            pend_d       = window_d;
            pend_valid_d = 1'b1;
          end
        end
      end
      TAIL: begin
        if (bus.s_in != exp_bit) begin
          frame_err_d = 1'b1;
          state_d     = HUNT;
          cnt_d       = '0;
        end else if (cnt == 6'd47) begin
          state_d = HUNT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = HUNT;
        cnt_d   = '0;
      end
    endcase

    // A full FIFO drops the held word for good; framing carries on as if it had been written.
    if (do_write) begin
      if (bus.wfull) begin
        overflow_d = 1'b1;
      end else begin
        w_en_d  = 1'b1;
        wdata_d = {write_eof, pend};
      end
    end
  end

  assign bus.w_en      = w_en_q;
  assign bus.wdata     = wdata_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overflow  = overflow_q;
  assign bus.in_frame  = (state == DATA);

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - scoreboard bench for serial_rx: directed frames plus randomized frame sequences
module tb_serial_rx;

  localparam logic [31:0] SOF = 32'h5a5a5a5a;
  localparam logic [15:0] EOFP = 16'h0f0f;

  logic rclk = 1'b0;
  logic rrst;
  always #5 rclk = ~rclk;

  serial_rx_if #(.DSIZE(32)) bus();

  serial_rx dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];
  int exp_err = 0, exp_ovf = 0;
  int seen_err = 0, seen_ovf = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every write, tallies error/overflow pulses.
  always @(posedge rclk) begin
    #1;
    if (rrst === 1'b0) begin
      if (bus.w_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %0h expected none", bus.wdata);
        end else begin
          check("wdata", {31'd0, bus.wdata}, {31'd0, exp_q.pop_front()});
        end
      end
      if (bus.frame_err === 1'b1) seen_err++;
      if (bus.overflow === 1'b1) seen_ovf++;
    end
  end

  task automatic send_bit(input logic b, input logic full);
    @(negedge rclk);
    bus.s_in  = b;
    bus.wfull = full;
  endtask

  task automatic send_sof();
    for (int i = 31; i >= 1; i--) send_bit(SOF[i], 1'b0);
    send_bit(SOF[0], 1'b0);
    check("in_frame_before_sof", {63'd0, bus.in_frame}, 64'd0);
    @(posedge rclk);
    #1;
    check("in_frame_after_sof", {63'd0, bus.in_frame}, 64'd1);
  endtask

  // Reference model: word k is written when word k+1 (or EOF) completes; last word flagged; a
  // write whose trigger bit coincides with wfull is lost and counted as an overflow.
  task automatic send_frame(input logic [31:0] words[$], input bit full[$], input int corrupt, input int gap);
    int n;
    logic [31:0] w;
    logic b;
    n = words.size();
    if (n == 0) exp_err++;
    for (int k = 0; k < n; k++) begin
      if (full[k]) exp_ovf++;
      else exp_q.push_back({(k == n - 1), words[k]});
    end
    if (corrupt >= 0) exp_err++;

    repeat (gap) send_bit(1'b0, 1'b0);
    send_sof();
    for (int k = 0; k < n; k++) begin
      w = words[k];
      for (int i = 31; i >= 0; i--)
        send_bit(w[i], (i == 0) && (k >= 1) && full[k - 1]);
    end
    for (int j = 0; j < 80; j++) begin
      b = EOFP[15 - (j % 16)];
      if (j == corrupt) b = ~b;
      send_bit(b, (j == 31) && (n > 0) && full[n - 1]);
      if (j == 31) check("in_frame_last_data_bit", {63'd0, bus.in_frame}, 64'd1);
      if (j == 32) check("in_frame_tail", {63'd0, bus.in_frame}, 64'd0);
    end
  endtask

  task automatic settle(input string tag);
    repeat (6) send_bit(1'b0, 1'b0);
    check({tag, "_pending_writes"}, exp_q.size(), 64'd0);
    check({tag, "_frame_err_count"}, seen_err, exp_err);
    check({tag, "_overflow_count"}, seen_ovf, exp_ovf);
    check({tag, "_in_frame_idle"}, {63'd0, bus.in_frame}, 64'd0);
  endtask

  initial begin
    logic [31:0] wq[$];
    bit          fq[$];
    logic [31:0] w2;

    rrst      = 1'b1;
    bus.s_in  = 1'b0;
    bus.wfull = 1'b0;
    repeat (3) @(negedge rclk);
    check("rst_w_en", {63'd0, bus.w_en}, 64'd0);
    check("rst_wdata", {31'd0, bus.wdata}, 64'd0);
    check("rst_in_frame", {63'd0, bus.in_frame}, 64'd0);
    check("rst_frame_err", {63'd0, bus.frame_err}, 64'd0);
    check("rst_overflow", {63'd0, bus.overflow}, 64'd0);
    rrst = 1'b0;

    // Idle line stays quiescent.
    repeat (100) send_bit(1'b0, 1'b0);
    settle("idle");

    wq = '{32'h12345678, 32'hdeadbeef}; fq = '{0, 0};
    send_frame(wq, fq, -1, 3);
    settle("two_words");

    wq = '{32'hcafef00d}; fq = '{0};
    send_frame(wq, fq, -1, 2);
    send_frame(wq, fq, -1, 0);
    settle("back_to_back");

    wq = '{}; fq = '{};
    send_frame(wq, fq, -1, 1);
    settle("empty_frame");

    wq = '{32'h11111111, 32'h22222222, 32'h33333333}; fq = '{1, 0, 0};
    send_frame(wq, fq, -1, 1);
    settle("wfull_first");

    wq = '{32'ha5a5f00f}; fq = '{0};
    send_frame(wq, fq, 40, 1);
    wq = '{32'h01020304, 32'h05060708}; fq = '{0, 0};
    send_frame(wq, fq, -1, 0);
    settle("corrupt_tail");

    // Reset midway through word 2: held word 1 must never appear.
    w2 = 32'h12345678;
    send_sof();
    for (int i = 31; i >= 0; i--) send_bit(w2[i], 1'b0);
    w2 = 32'h9abcdef0;
    for (int i = 31; i >= 16; i--) send_bit(w2[i], 1'b0);
    @(negedge rclk);
    rrst = 1'b1;
    #1;
    check("midrst_w_en", {63'd0, bus.w_en}, 64'd0);
    check("midrst_wdata", {31'd0, bus.wdata}, 64'd0);
    check("midrst_in_frame", {63'd0, bus.in_frame}, 64'd0);
    check("midrst_frame_err", {63'd0, bus.frame_err}, 64'd0);
    check("midrst_overflow", {63'd0, bus.overflow}, 64'd0);
    @(negedge rclk);
    rrst = 1'b0;
    wq = '{32'hfeedface, 32'h0badc0de}; fq = '{0, 0};
    send_frame(wq, fq, -1, 2);
    settle("after_reset");

    for (int f = 0; f < 25; f++) begin
      int n, corrupt, gap;
      logic [31:0] w;
      n = $urandom_range(0, 4);
      wq = '{}; fq = '{};
      for (int k = 0; k < n; k++) begin
        w = $urandom;
        if (w == 32'h0f0f0f0f) w = w ^ 32'h1;
        wq.push_back(w);
        fq.push_back($urandom_range(0, 4) == 0);
      end
      corrupt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(32, 79)) : -1;
      gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
      send_frame(wq, fq, corrupt, gap);
    end
    settle("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- Downstream deserializer for the serial frame stream produced by the transmit stage.
- Samples one line bit per rclk, hunts for start-of-frame, and assembles 32-bit payload words.
- Detects end-of-frame and writes each word, with its end-of-frame flag in bit DSIZE, into a receive FIFO write port.
- Receive-side mirror of the transmit path's FIFO read interface.

Parameters:
DSIZE, 32, payload width; FIFO word is DSIZE+1 bits (bit DSIZE = last-word-of-frame flag); only 32 supported
SOF_PAT, 32'h5a5a5a5a, start-of-frame pattern (SOF word 16'h5a5a sent twice)
EOF_PAT, 16'h0f0f, end-of-frame word; sent 5 times (80 bits)

Ports:
rclk  input  1  clock; one line bit per cycle
rrst  input  1  asynchronous, active-high reset
s_in  input  1  serial line, idle 0, MSB first
wfull  input  1  receive FIFO full
w_en  output  1  FIFO write strobe, one cycle per word
wdata  output  DSIZE+1  {eof_flag, payload word}
in_frame  output  1  high from SOF match until EOF match/abort
frame_err  output  1  one-cycle pulse on protocol error
overflow  output  1  one-cycle pulse when a word is dropped on wfull

Behaviour:
- Reset (asynchronous, any time, including mid-frame): state HUNT, shift window 0, bit counter 0, pending-word valid 0; w_en, wdata, in_frame, frame_err, overflow all 0. A partially received frame is discarded; nothing is written.
- Wire format: SOF_PAT (32 bits), N>=1 payload words of 32 bits each (bits 31..0, MSB first), then EOF_PAT x5. Payload value 32'h0f0f0f0f is reserved and is always decoded as EOF.
- 32-bit shift window: window <= {window[30:0], s_in} every cycle in every state.
- States:
  - HUNT: in_frame=0. When the window after the shift equals SOF_PAT, go to DATA with the bit counter cleared.
  - DATA: in_frame=1. Count 32 bits. On the 32nd bit, take the assembled word W:
    - W == {EOF_PAT,EOF_PAT}: if a pending word exists, write it with eof=1, then go to TAIL. If no pending word (empty frame), pulse frame_err and go to TAIL without writing.
    - Otherwise: if a pending word exists, write it with eof=0. Then pending <= W and pending-valid <= 1.
  - TAIL: in_frame=0. Check the remaining 48 bits against EOF_PAT bit-by-bit (expected bit = EOF_PAT[15 - (cnt mod 16)]).
    - Any mismatch: pulse frame_err, go to HUNT.
    - After 48 bits: go to HUNT.
    - A back-to-back frame (EOF followed directly by SOF) must be caught: the window keeps shifting in TAIL, and HUNT matches SOF 32 cycles after TAIL exits.
- Write timing: w_en is registered and asserts in the cycle after the cycle in which the 32nd bit of the triggering word is sampled. wdata is valid in the same cycle as w_en. wdata holds its value otherwise.
- One-word holdback: each word is written only when the next word or the EOF arrives, so the final word carries eof=1.
- wfull sampled in the write-decision cycle while high: write suppressed, overflow pulses, word lost. Pending/state logic continues unchanged. No retry.
- Idle line (all 0) never matches SOF_PAT. HUNT stays quiescent.
- Pending-valid is cleared on entry to TAIL and on reset.
- Bit counter: 6 bits, cleared on every state change, no wrap inside a state.

Test Plan:
- SOF, words 32'h12345678 and 32'hdeadbeef, EOF x5 -> w_en pulses twice: wdata=33'h0_12345678 (one cycle after bit 32 of word 2), then 33'h1_deadbeef (one cycle after bit 32 of EOF). No frame_err. Back in HUNT 48 cycles later.
- Two frames back-to-back (EOF x5 then SOF with no idle gap), each with one word 32'hcafef00d -> two writes of 33'h1_cafef00d. in_frame re-asserts exactly when the second SOF's 32nd bit is sampled.
- SOF immediately followed by EOF -> no w_en, frame_err pulses once, returns to HUNT.
- wfull=1 during the first write of a 3-word frame -> overflow pulses once. Only words 2 and 3 are written (word 3 with eof=1).
- Corrupt EOF tail (flip bit 40 of EOF) -> last word is still written with eof=1, frame_err pulses at the flipped bit, state returns to HUNT. A following valid frame is received correctly.
- Assert rrst for one cycle midway through word 2 -> all outputs 0 immediately, no writes. A fresh frame afterwards is received normally.
